// File: rtl/exc_entry_seq.sv
// Exception entry sequencer: on an accepted exception it switches mode, then writes LR (R14)
// and the vector (R15) into the register file and pulses Ack. Define EXC_HIVEC_EN for high vectors.
module exc_entry_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        Exc_Req,
    input  logic [2:0]  Exc_Type,
    input  logic [31:0] PC_In,
    input  logic        Mod_Wr,
    input  logic [4:0]  Mod_WData,
    output logic [4:0]  Mod,
    output logic [4:0]  Save_Mod,
    output logic [3:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        Write_Reg,
    output logic        Busy,
    output logic        Ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LR = 2'd1,
        WR_PC = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef EXC_HIVEC_EN
    localparam logic [31:0] VEC_BASE = 32'hFFFF_0000;
`else
    localparam logic [31:0] VEC_BASE = 32'h0000_0000;
`endif

    localparam logic [4:0] RESET_MODE = 5'h16;

    function automatic logic type_valid(input logic [2:0] t);
        return (t != 3'd0) && (t != 3'd7);
    endfunction

    function automatic logic [4:0] exc_mode(input logic [2:0] t);
        logic [4:0] m;
        case (t)
            3'd1:    m = 5'h17;
            3'd2:    m = 5'h16;
            3'd3:    m = 5'h13;
            3'd4:    m = 5'h13;
            3'd5:    m = 5'h12;
            3'd6:    m = 5'h11;
            default: m = RESET_MODE;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] exc_vec_off(input logic [2:0] t);
        logic [31:0] o;
        case (t)
            3'd1:    o = 32'h04;
            3'd2:    o = 32'h08;
            3'd3:    o = 32'h0C;
            3'd4:    o = 32'h10;
            3'd5:    o = 32'h18;
            3'd6:    o = 32'h1C;
            default: o = 32'h00;
        endcase
        return o;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  mod_q, mod_d;
    logic [4:0]  save_mod_q, save_mod_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] vec_q, vec_d;

    // State and latched entry values; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mod_q      <= RESET_MODE;
            save_mod_q <= RESET_MODE;
            lr_q       <= 32'h0;
            vec_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            mod_q      <= mod_d;
            save_mod_q <= save_mod_d;
            lr_q       <= lr_d;
            vec_q      <= vec_d;
        end
    end

    // Next-state logic; requests and mode writes are only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        save_mod_d = save_mod_q;
        lr_d       = lr_q;
        vec_d      = vec_q;
        case (state_q)
            IDLE: begin
                if (Exc_Req && type_valid(Exc_Type)) begin
                    // Exception wins over a simultaneous mode write.
                    state_d    = WR_LR;
                    save_mod_d = mod_q;
                    mod_d      = exc_mode(Exc_Type);
                    lr_d       = PC_In + ((Exc_Type == 3'd4) ? 32'd8 : 32'd4);
                    vec_d      = VEC_BASE + exc_vec_off(Exc_Type);
                end else if (Mod_Wr) begin
                    mod_d = Mod_WData;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_LR:   state_d = WR_PC;
            WR_PC:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register-file and handshake outputs depend on the state register only.
    always_comb begin
        W_Addr    = 4'h0;
        W_Data    = 32'h0;
        Write_Reg = 1'b0;
        Busy      = 1'b1;
        Ack       = 1'b0;
        case (state_q)
            IDLE:  Busy = 1'b0;
            WR_LR: begin
                Write_Reg = 1'b1;
                W_Addr    = 4'hE;
                W_Data    = lr_q;
            end
            WR_PC: begin
                Write_Reg = 1'b1;
                W_Addr    = 4'hF;
                W_Data    = vec_q;
            end
            DONE:    Ack  = 1'b1;
            default: Busy = 1'b0;
        endcase
    end

    assign Mod      = mod_q;
    assign Save_Mod = save_mod_q;

endmodule

// File: tb/tb_exc_entry_seq.sv
// Directed bench for exc_entry_seq with hand-computed expectations.
module tb_exc_entry_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        Exc_Req;
    logic [2:0]  Exc_Type;
    logic [31:0] PC_In;
    logic        Mod_Wr;
    logic [4:0]  Mod_WData;
    logic [4:0]  Mod;
    logic [4:0]  Save_Mod;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic        Busy;
    logic        Ack;

    int total = 0;
    int bad   = 0;

`ifdef EXC_HIVEC_EN
    localparam logic [31:0] BASE = 32'hFFFF_0000;
`else
    localparam logic [31:0] BASE = 32'h0000_0000;
`endif

    exc_entry_seq dut (
        .clk       (clk),
        .rst       (rst),
        .Exc_Req   (Exc_Req),
        .Exc_Type  (Exc_Type),
        .PC_In     (PC_In),
        .Mod_Wr    (Mod_Wr),
        .Mod_WData (Mod_WData),
        .Mod       (Mod),
        .Save_Mod  (Save_Mod),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .Write_Reg (Write_Reg),
        .Busy      (Busy),
        .Ack       (Ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full output set in one call.
    task automatic chk_out(input string tag, input logic [4:0] m, input logic [4:0] sm,
                           input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                           input logic bz, input logic ak);
        chk({tag, ".Mod"},       {27'd0, Mod},       {27'd0, m});
        chk({tag, ".Save_Mod"},  {27'd0, Save_Mod},  {27'd0, sm});
        chk({tag, ".Write_Reg"}, {31'd0, Write_Reg}, {31'd0, wr});
        chk({tag, ".W_Addr"},    {28'd0, W_Addr},    {28'd0, wa});
        chk({tag, ".W_Data"},    W_Data,             wd);
        chk({tag, ".Busy"},      {31'd0, Busy},      {31'd0, bz});
        chk({tag, ".Ack"},       {31'd0, Ack},       {31'd0, ak});
    endtask

    initial begin
        rst = 1'b1; Exc_Req = 1'b0; Exc_Type = 3'd0; PC_In = 32'h0;
        Mod_Wr = 1'b0; Mod_WData = 5'h0;
        #2;
        chk_out("reset", 5'h16, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // Software mode write in IDLE leaves Save_Mod alone.
        Mod_Wr = 1'b1; Mod_WData = 5'h10;
        tick();
        Mod_Wr = 1'b0;
        chk_out("msr", 5'h10, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

        // SVC entry with fixed three-cycle latency.
        Exc_Req = 1'b1; Exc_Type = 3'd2; PC_In = 32'h100;
        tick();
        Exc_Req = 1'b0;
        chk_out("svc.lr", 5'h16, 5'h10, 1'b1, 4'hE, 32'h104, 1'b1, 1'b0);
        tick();
        chk_out("svc.pc", 5'h16, 5'h10, 1'b1, 4'hF, BASE + 32'h08, 1'b1, 1'b0);
        tick();
        chk_out("svc.done", 5'h16, 5'h10, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
        tick();
        chk_out("svc.idle", 5'h16, 5'h10, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

        // DABT uses PC+8.
        Exc_Req = 1'b1; Exc_Type = 3'd4; PC_In = 32'h2000;
        tick();
        Exc_Req = 1'b0;
        chk_out("dabt.lr", 5'h13, 5'h16, 1'b1, 4'hE, 32'h2008, 1'b1, 1'b0);
        tick();
        chk_out("dabt.pc", 5'h13, 5'h16, 1'b1, 4'hF, BASE + 32'h10, 1'b1, 1'b0);
        tick(); tick();

        // FIQ with LR wrapping to zero.
        Exc_Req = 1'b1; Exc_Type = 3'd6; PC_In = 32'hFFFF_FFFC;
        tick();
        Exc_Req = 1'b0;
        chk_out("fiq.lr", 5'h11, 5'h13, 1'b1, 4'hE, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("fiq.pc", 5'h11, 5'h13, 1'b1, 4'hF, BASE + 32'h1C, 1'b1, 1'b0);
        tick(); tick();

        // IRQ collides with a mode write; further requests while busy are dropped.
        Exc_Req = 1'b1; Exc_Type = 3'd5; PC_In = 32'h300;
        Mod_Wr = 1'b1; Mod_WData = 5'h1F;
        tick();
        Exc_Type = 3'd3; PC_In = 32'h500;
        chk_out("irq.lr", 5'h12, 5'h11, 1'b1, 4'hE, 32'h304, 1'b1, 1'b0);
        tick();
        chk_out("irq.pc", 5'h12, 5'h11, 1'b1, 4'hF, BASE + 32'h18, 1'b1, 1'b0);
        tick();
        chk_out("irq.done", 5'h12, 5'h11, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
        Exc_Req = 1'b0; Mod_Wr = 1'b0;
        tick();
        chk_out("irq.idle", 5'h12, 5'h11, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Request held through DONE is taken again after one IDLE cycle.
        Exc_Req = 1'b1; Exc_Type = 3'd1; PC_In = 32'h40;
        tick();
        chk_out("und.lr", 5'h17, 5'h12, 1'b1, 4'hE, 32'h44, 1'b1, 1'b0);
        tick(); tick();
        chk_out("und.done", 5'h17, 5'h12, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
        tick();
        chk_out("und.idle", 5'h17, 5'h12, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        Exc_Req = 1'b0;
        chk_out("und.re", 5'h17, 5'h17, 1'b1, 4'hE, 32'h44, 1'b1, 1'b0);
        tick();
        chk_out("und.pc", 5'h17, 5'h17, 1'b1, 4'hF, BASE + 32'h04, 1'b1, 1'b0);

        // Asynchronous reset in WR_PC aborts without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_out("abort", 5'h16, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_out("abort.hold", 5'h16, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

        // First edge after reset release accepts a request.
        rst = 1'b0; Exc_Req = 1'b1; Exc_Type = 3'd2; PC_In = 32'h0;
        tick();
        Exc_Req = 1'b0;
        chk_out("post_rst", 5'h16, 5'h16, 1'b1, 4'hE, 32'h4, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk_out("post_rst.idle", 5'h16, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Invalid types are ignored.
        Exc_Req = 1'b1; Exc_Type = 3'd0; PC_In = 32'h80;
        tick();
        chk_out("type0", 5'h16, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        Exc_Type = 3'd7;
        tick();
        chk_out("type7", 5'h16, 5'h16, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        Exc_Req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_entry_seq.md
EXC_ENTRY_SEQ -- requirements
Module: exc_entry_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock, shared with the general register file.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 Exc_Req  input  1  exception request, level-sampled in IDLE.
REQ-005 Exc_Type  input  3  exception type codes: 1=UND, 2=SVC, 3=PABT, 4=DABT, 5=IRQ, 6=FIQ; codes 0 and 7 are invalid.
REQ-006 PC_In  input  32  address of the excepting instruction.
REQ-007 Mod_Wr  input  1  software mode-write strobe (MSR).
REQ-008 Mod_WData  input  5  software mode value.
REQ-009 Mod  output  5  current processor mode; drives the register file Mod port.
REQ-010 Save_Mod  output  5  mode held before the last exception entry.
REQ-011 W_Addr  output  4  register file write address.
REQ-012 W_Data  output  32  register file write data.
REQ-013 Write_Reg  output  1  register file write enable.
REQ-014 Busy  output  1  entry sequence in progress.
REQ-015 Ack  output  1  one-cycle pulse on entry completion.

Function
REQ-016 The state machine SHALL have the states IDLE, WR_LR, WR_PC and DONE; the reset state SHALL be IDLE.
REQ-017 In IDLE, Exc_Req=1 with a valid Exc_Type SHALL be accepted at the clock edge, and the state SHALL move to WR_LR.
REQ-018 Exc_Req with an invalid Exc_Type SHALL be ignored, with no change to state or outputs.
REQ-019 At the accept edge, Save_Mod SHALL take the old Mod value and Mod SHALL take the new mode: UND 5'h17, SVC 5'h16, PABT/DABT 5'h13, IRQ 5'h12, FIQ 5'h11.
REQ-020 At the accept edge, the LR value SHALL be latched as PC_In+8 for DABT and PC_In+4 for all other types, using 32-bit modulo arithmetic (0xFFFFFFFC+8 = 0x00000004).
REQ-021 At the accept edge, the vector address SHALL be latched as base+offset, where the offset is UND 0x04, SVC 0x08, PABT 0x0C, DABT 0x10, IRQ 0x18, FIQ 0x1C.
REQ-022 In WR_LR, the outputs SHALL be Write_Reg=1, W_Addr=4'hE and W_Data=the latched LR value, and the next state SHALL be WR_PC.
REQ-023 In WR_PC, the outputs SHALL be Write_Reg=1, W_Addr=4'hF and W_Data=the latched vector, and the next state SHALL be DONE.
REQ-024 In DONE, the outputs SHALL be Ack=1 and Write_Reg=0, and the next state SHALL be IDLE; Ack SHALL be asserted in exactly one cycle per accepted request.
REQ-025 Busy SHALL be 1 in WR_LR, WR_PC and DONE, and 0 in IDLE.
REQ-026 Latency SHALL be fixed: writes occur in cycles 1 and 2 after the accept edge, and Ack occurs in cycle 3.
REQ-027 Exc_Req and Mod_Wr SHALL be ignored while Busy=1, and no request SHALL be queued.
REQ-028 In IDLE, Mod_Wr=1 SHALL load Mod_WData into Mod at the clock edge without changing Save_Mod.
REQ-029 If Exc_Req (valid type) and Mod_Wr are both asserted in the same IDLE cycle, the exception SHALL win and Mod_Wr SHALL be dropped.
REQ-030 In IDLE, the outputs SHALL be Write_Reg=0, W_Addr=0 and W_Data=0.
REQ-031 Write_Reg, W_Addr, W_Data, Busy and Ack SHALL be decoded only from the state register, with no combinational path from the inputs.
REQ-032 A request held high through DONE SHALL be re-accepted in the first IDLE cycle after DONE.

Reset
REQ-033 While rst=1, the block SHALL force state=IDLE, Mod=5'h16, Save_Mod=5'h16, Write_Reg=0, W_Addr=0, W_Data=0, Busy=0, Ack=0, and clear the latched LR and vector values to 0.
REQ-034 Reset asserted mid-sequence SHALL abort the sequence immediately, without waiting for clk, with no further register writes and no Ack.
REQ-035 The first acceptance after rst deasserts SHALL be possible at the first rising clk edge.

Configuration
REQ-036 When the macro EXC_HIVEC_EN is defined, the vector base SHALL be 32'hFFFF0000.
REQ-037 When EXC_HIVEC_EN is undefined, the vector base SHALL be 32'h00000000; no other behaviour SHALL differ between the two builds.

Verification
REQ-038 SVC accept: Mod=5'h10, Exc_Type=2, PC_In=0x100 -> Mod=5'h16, Save_Mod=5'h10; write R14=0x104, then R15=0x08, then Ack after 3 cycles.
REQ-039 DABT with EXC_HIVEC_EN defined: PC_In=0x2000 -> Mod=5'h13; write R14=0x2008, then R15=0xFFFF0010.
REQ-040 Wrap: FIQ with PC_In=0xFFFFFFFC -> R14=0x00000000, R15=0x1C, Mod=5'h11.
REQ-041 Collision: Exc_Type=5 and Mod_Wr=1 (Mod_WData=5'h1F) in the same cycle -> Mod=5'h12; a second request during Busy is ignored, giving a single Ack.
REQ-042 Reset while in WR_PC -> Write_Reg=0 immediately, Mod=5'h16, no Ack; Exc_Type=0 with Exc_Req=1 -> no state change.
